snake_pixel_gen: RTL and testbench

SNAKE_PIXEL_GEN -- requirements
Module: snake_pixel_gen

---
 rtl/snake_pixel_gen.sv | 109 ++++++++++
 tb/tb_snake_pixel_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/snake_pixel_gen.sv
// snake_pixel_gen: two-stage pipeline that turns cell-map codes into 1-bit-per-channel VGA colour.
// Optional macro SNAKE_BORDER_EN paints the outer ring of cells white (111).
module snake_pixel_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [9:0]  x_dis,
    input  logic [9:0]  y_dis,
    input  logic        game_over,
    output logic [10:0] map_addr,
    input  logic [1:0]  map_data,
    output logic        nvga_r,
    output logic        nvga_g,
    output logic        nvga_b,
    output logic        frame_tick
);

    logic [5:0]  cell_x;
    logic [4:0]  cell_y;
    logic        inb;
    logic        pix_valid;
    logic        last_pixel;
    logic [10:0] addr_next;
    logic        de_d1;
    logic        flash_d1;
    logic [3:0]  frame_cnt;
    logic [2:0]  rgb_next;
`ifdef SNAKE_BORDER_EN
    logic        border_d1;
`endif

    assign cell_x     = x_dis[9:4];
    assign cell_y     = y_dis[8:4];
    assign inb        = (x_dis < 10'd640) && (y_dis < 10'd480);
    assign pix_valid  = de && inb;
    assign last_pixel = de && (x_dis == 10'd639) && (y_dis == 10'd479);

    // cell_y*40 built from shifts; the widest result (1199) fits in 11 bits
    assign addr_next = {1'b0, cell_y, 5'b00000} + {3'b000, cell_y, 3'b000} + {5'b00000, cell_x};

    // Stage 0: address is held while blanked so the RAM does not see spurious reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_addr <= '0;
            de_d1    <= 1'b0;
            flash_d1 <= 1'b0;
        end else begin
            if (pix_valid) begin
                map_addr <= addr_next;
            end
            de_d1    <= pix_valid;
            flash_d1 <= game_over && frame_cnt[3];
        end
    end

`ifdef SNAKE_BORDER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            border_d1 <= 1'b0;
        end else begin
            border_d1 <= (cell_x == 6'd0) || (cell_x == 6'd39) ||
                         (cell_y == 5'd0) || (cell_y == 5'd29);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= last_pixel;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

    // Stage 1 colour: snake segments flash red during the game-over blink phase
    always_comb begin
        rgb_next = 3'b000;
        if (de_d1) begin
            case (map_data)
                2'b01:   rgb_next = flash_d1 ? 3'b100 : 3'b010;
                2'b10:   rgb_next = flash_d1 ? 3'b100 : 3'b110;
                2'b11:   rgb_next = 3'b100;
                default: rgb_next = 3'b000;
            endcase
`ifdef SNAKE_BORDER_EN
            if (border_d1) begin
                rgb_next = 3'b111;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nvga_r <= 1'b0;
            nvga_g <= 1'b0;
            nvga_b <= 1'b0;
        end else begin
            nvga_r <= rgb_next[2];
            nvga_g <= rgb_next[1];
            nvga_b <= rgb_next[0];
        end
    end

endmodule

// File: tb/tb_snake_pixel_gen.sv
// Directed bench for snake_pixel_gen; the cell-map RAM is modelled as map_data = map_addr[1:0].
// Border expectations follow SNAKE_BORDER_EN when it is defined for the build.
module tb_snake_pixel_gen;

`ifdef SNAKE_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [9:0]  x_dis;
    logic [9:0]  y_dis;
    logic        game_over;
    logic [10:0] map_addr;
    logic [1:0]  map_data;
    logic        nvga_r, nvga_g, nvga_b;
    logic        frame_tick;
    logic [2:0]  rgb;

    int    checks = 0;
    int    errors = 0;
    int    tick_count = 0;
    int    model_addr = 0;
    int    model_tick = 0;
    int    exp_q[$];
    string phase = "reset";

    snake_pixel_gen dut (
        .clk(clk), .rst(rst), .de(de), .x_dis(x_dis), .y_dis(y_dis),
        .game_over(game_over), .map_addr(map_addr), .map_data(map_data),
        .nvga_r(nvga_r), .nvga_g(nvga_g), .nvga_b(nvga_b), .frame_tick(frame_tick)
    );

    always #20 clk = ~clk;

    // Combinational stand-in for the RAM so data is ready in the cycle after the address
    assign map_data = map_addr[1:0];
    assign rgb      = {nvga_r, nvga_g, nvga_b};

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One pixel per cycle: check what the previous pixels produced, then drive the next one
    task automatic applyStimulus(input bit r, input bit d, input int x, input int y,
                                 input bit go, input int exp_rgb);
        @(negedge clk);
        checkOutput({phase, " addr"}, int'(map_addr), model_addr);
        checkOutput({phase, " tick"}, int'(frame_tick), model_tick);
        if (frame_tick) tick_count++;
        if (exp_q.size() == 2) checkOutput({phase, " rgb"}, int'(rgb), exp_q.pop_front());
        rst       = r;
        de        = d;
        x_dis     = x[9:0];
        y_dis     = y[9:0];
        game_over = go;
        exp_q.push_back(r ? 0 : exp_rgb);
        if (!r && d && x < 640 && y < 480) model_addr = (y / 16) * 40 + x / 16;
        model_tick = (!r && d && x == 639 && y == 479) ? 1 : 0;
    endtask

    function automatic int codeRgb(input int code);
        case (code)
            0:       return 0;
            1:       return 2;
            2:       return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int pixelRgb(input int x, input int y);
        int cx = x / 16;
        int cy = y / 16;
        if (BORDER_ON && (cx == 0 || cx == 39 || cy == 0 || cy == 29)) return 7;
        return codeRgb((cy * 40 + cx) % 4);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; de = 1'b0; x_dis = '0; y_dis = '0; game_over = 1'b0;

        // Reset held while de toggles, including the end-of-frame pixel
        for (int i = 0; i < 6; i++)
            applyStimulus(1, i[0], (i % 3 == 0) ? 639 : 35, (i % 3 == 0) ? 479 : 50, 1, 0);

        // Release: (35,50) -> cell (2,3) -> addr 122 -> code 10 -> yellow
        phase = "release";
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 35, 50, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Colour table: addresses 44,41,42,43 carry codes 00,01,10,11
        phase = "colour";
        applyStimulus(0, 1, 64, 16, 0, 0);
        applyStimulus(0, 1, 16, 16, 0, 2);
        applyStimulus(0, 1, 32, 16, 0, 6);
        applyStimulus(0, 1, 48, 16, 0, 4);

        // Blanking: de low and out-of-range coordinates hold the address and give black
        phase = "blank";
        applyStimulus(0, 1, 100, 100, 0, 6);
        applyStimulus(0, 0, 200, 200, 0, 0);
        applyStimulus(0, 1, 700, 20, 0, 0);
        applyStimulus(0, 1, 300, 480, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Border cells: (5,200) code 00, (630,16) code 11, (100,470) code 10
        phase = "border";
        applyStimulus(0, 1, 5, 200, 0, BORDER_ON ? 7 : 0);
        applyStimulus(0, 1, 630, 16, 1, BORDER_ON ? 7 : 4);
        applyStimulus(0, 1, 100, 470, 0, BORDER_ON ? 7 : 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Sixteen frames with game_over high: segments red once frame_cnt[3] is set
        phase = "frames";
        tick_count = 0;
        for (int f = 0; f < 16; f++) begin
            applyStimulus(0, 1, 16, 16, 1, (f >= 8) ? 4 : 2);
            applyStimulus(0, 1, 32, 16, 1, (f >= 8) ? 4 : 6);
            applyStimulus(0, 1, 48, 16, 1, 4);
            applyStimulus(0, 1, 64, 16, 1, 0);
            applyStimulus(0, 1, 16, 16, 0, 2);
            applyStimulus(0, 1, 639, 479, 1, BORDER_ON ? 7 : 4);
            applyStimulus(0, 0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 1, 16, 16, 1, 2);
        applyStimulus(0, 1, 32, 16, 1, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("frame tick count", tick_count, 16);

        // Full row streamed back to back
        phase = "stream";
        for (int x = 0; x < 640; x++)
            applyStimulus(0, 1, x, 16, 0, pixelRgb(x, 16));
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Mid-frame reset blanks the colour without waiting for a clock edge
        phase = "async";
        applyStimulus(0, 1, 48, 16, 0, 4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("async pre rgb", int'(rgb), exp_q.pop_front());
        rst = 1'b1;
        #1;
        checkOutput("async rgb", int'(rgb), 0);
        checkOutput("async addr", int'(map_addr), 0);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(0);
        model_addr = 0;
        model_tick = 0;
        applyStimulus(1, 1, 35, 50, 0, 0);
        applyStimulus(0, 1, 35, 50, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
